// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-engine state enum, default sizes and the address rule.
package rf_pkg;

   typedef enum logic [1:0] {
      RF_IDLE,
      RF_CLEAR,
      RF_DONE
   } rf_clr_state_e;

   localparam int RF_DATA_W   = 24;
   localparam int RF_NUM_REGS = 16;
   localparam int RF_ADDR_W   = 4;
   localparam int RF_NUM_RD   = 3;
   localparam int RF_EXT_IDX  = 11;

   // An address owns a storage entry only if it is in range and is not
   // the externally sourced slot.
   function automatic logic rf_addr_valid(input int addr,
                                          input int num_regs,
                                          input int ext_idx);
      return (addr != ext_idx) && (addr < num_regs);
   endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus between pipeline stages and register_file_mp.
// master: decode/writeback side (ra, we/wa/wd, ext_val, pend_set/pend_addr,
// clr_req); slave: register file (rd, rd_pend, pending, clr_busy, clr_done).
interface register_file_mp_if
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD
);
   logic [NUM_RD-1:0][ADDR_W-1:0] ra;
   logic [NUM_RD-1:0][DATA_W-1:0] rd;
   logic [NUM_RD-1:0]             rd_pend;
   logic                          we;
   logic [ADDR_W-1:0]             wa;
   logic [DATA_W-1:0]             wd;
   logic [DATA_W-1:0]             ext_val;
   logic                          pend_set;
   logic [ADDR_W-1:0]             pend_addr;
   logic [NUM_REGS-1:0]           pending;
   logic                          clr_req;
   logic                          clr_busy;
   logic                          clr_done;

   modport master (
      output ra, we, wa, wd, ext_val, pend_set, pend_addr, clr_req,
      input  rd, rd_pend, pending, clr_busy, clr_done
   );

   modport slave (
      input  ra, we, wa, wd, ext_val, pend_set, pend_addr, clr_req,
      output rd, rd_pend, pending, clr_busy, clr_done
   );
endinterface

// File: rtl/register_file_mp_read_port.sv
// One combinational read port: ext slot, range check, optional bypass.
// Ports: ra in, mem/pend/ext_val state in, commit info in, rd/rd_pend out.
// Macro RF_BYPASS_EN enables same-cycle write-through.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int EXT_IDX  = RF_EXT_IDX
) (
   input  logic [ADDR_W-1:0]                ra,
   input  logic [NUM_REGS-1:0][DATA_W-1:0]  mem,
   input  logic [NUM_REGS-1:0]              pend,
   input  logic [DATA_W-1:0]                ext_val,
   input  logic                             wr_ok,
   input  logic [ADDR_W-1:0]                wa,
   input  logic [DATA_W-1:0]                wd,
   input  logic                             set_ok,
   input  logic [ADDR_W-1:0]                pend_addr,
   output logic [DATA_W-1:0]                rd,
   output logic                             rd_pend
);
`ifndef RF_BYPASS_EN
   logic bp_unused;
   assign bp_unused = ^{wr_ok, wa, wd, set_ok, pend_addr};
`endif

   always_comb begin
      rd      = '0;
      rd_pend = 1'b0;
      if (32'(ra) == EXT_IDX) begin
         rd = ext_val;
      end else if (rf_addr_valid(32'(ra), NUM_REGS, EXT_IDX)) begin
         rd      = mem[ra];
         rd_pend = pend[ra];
`ifdef RF_BYPASS_EN
         // A committing write is seen now; pending only if re-issued.
         if (wr_ok && (wa == ra)) begin
            rd      = wd;
            rd_pend = set_ok && (pend_addr == ra);
         end
`endif
      end
   end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with scoreboard bits and a clear sweep engine.
// Ports: clk, rst (async active-high), bus (register_file_mp_if.slave).
// Macro RF_BYPASS_EN enables write-through on the read ports.
module register_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int NUM_RD   = RF_NUM_RD,
   parameter int EXT_IDX  = RF_EXT_IDX
) (
   input logic clk,
   input logic rst,
   register_file_mp_if.slave bus
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

   logic [NUM_REGS-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [NUM_REGS-1:0]             pend_q, pend_d;
   rf_clr_state_e                   state_q;
   logic [ADDR_W-1:0]               cnt_q;
   logic                            busy_q, done_q;
   logic                            wr_ok, set_ok, clearing;
   logic [NUM_RD-1:0][DATA_W-1:0]   rd_w;
   logic [NUM_RD-1:0]               rd_pend_w;

   assign clearing = (state_q == RF_CLEAR);
   assign wr_ok    = bus.we && (state_q == RF_IDLE) &&
                     rf_addr_valid(32'(bus.wa), NUM_REGS, EXT_IDX);
   assign set_ok   = bus.pend_set &&
                     rf_addr_valid(32'(bus.pend_addr), NUM_REGS, EXT_IDX);

   // Order matters: set overrides a same-address write, clear
   // overrides a same-address set.
   always_comb begin
      mem_d  = mem_q;
      pend_d = pend_q;
      if (wr_ok) begin
         mem_d[bus.wa]  = bus.wd;
         pend_d[bus.wa] = 1'b0;
      end
      if (set_ok && !(clearing && (bus.pend_addr == cnt_q))) begin
         pend_d[bus.pend_addr] = 1'b1;
      end
      if (clearing) begin
         mem_d[cnt_q]  = '0;
         pend_d[cnt_q] = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q  <= '0;
         pend_q <= '0;
      end else begin
         mem_q  <= mem_d;
         pend_q <= pend_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RF_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            RF_IDLE: begin
               if (bus.clr_req) begin
                  state_q <= RF_CLEAR;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            RF_CLEAR: begin
               if (cnt_q == LAST) begin
                  state_q <= RF_DONE;
                  cnt_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RF_DONE: begin
               state_q <= RF_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= RF_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      rf_read_port #(
         .DATA_W  (DATA_W),
         .NUM_REGS(NUM_REGS),
         .ADDR_W  (ADDR_W),
         .EXT_IDX (EXT_IDX)
      ) u_rd (
         .ra       (bus.ra[i]),
         .mem      (mem_q),
         .pend     (pend_q),
         .ext_val  (bus.ext_val),
         .wr_ok    (wr_ok),
         .wa       (bus.wa),
         .wd       (bus.wd),
         .set_ok   (set_ok),
         .pend_addr(bus.pend_addr),
         .rd       (rd_w[i]),
         .rd_pend  (rd_pend_w[i])
      );
   end

   assign bus.rd       = rd_w;
   assign bus.rd_pend  = rd_pend_w;
   assign bus.pending  = pend_q;
   assign bus.clr_busy = busy_q;
   assign bus.clr_done = done_q;
endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: reference model plus
// directed vectors with literal expectations.
module tb_register_file_mp;
   localparam int DW  = 24;
   localparam int NR  = 16;
   localparam int AW  = 4;
   localparam int RD  = 3;
   localparam int EXT = 11;
   localparam logic [DW-1:0] EXTV = 24'h000ABC;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   register_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW),
                         .NUM_RD(RD)) bus ();
   register_file_mp_if #(.DATA_W(DW), .NUM_REGS(12), .ADDR_W(AW),
                         .NUM_RD(RD)) bus2 ();

   register_file_mp #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW),
                      .NUM_RD(RD), .EXT_IDX(EXT))
      dut (.clk(clk), .rst(rst), .bus(bus));
   register_file_mp #(.DATA_W(DW), .NUM_REGS(12), .ADDR_W(AW),
                      .NUM_RD(RD), .EXT_IDX(EXT))
      dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   // Model state: array contents, scoreboard, and sweep position
   // (-1 idle, 0..NR-1 entry being cleared, NR done cycle).
   logic [DW-1:0] m_mem [NR];
   logic [NR-1:0] m_pend;
   int            m_pos = -1;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
      end
   endtask

   function automatic bit ok_addr(input int a);
      return (a != EXT) && (a < NR);
   endfunction

   function automatic bit commit_to(input int a);
      return (m_pos < 0) && bus.we && ok_addr(int'(bus.wa)) &&
             (int'(bus.wa) == a);
   endfunction

   function automatic logic [DW-1:0] exp_rd(input int a);
      if (a == EXT) return bus.ext_val;
      if (!ok_addr(a)) return '0;
`ifdef RF_BYPASS_EN
      if (commit_to(a)) return bus.wd;
`endif
      return m_mem[a];
   endfunction

   function automatic logic exp_pend(input int a);
      if (!ok_addr(a)) return 1'b0;
`ifdef RF_BYPASS_EN
      if (commit_to(a))
         return bus.pend_set && (int'(bus.pend_addr) == a);
`endif
      return m_pend[a];
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         foreach (m_mem[i]) m_mem[i] <= '0;
         m_pend <= '0;
         m_pos  <= -1;
      end else begin
         if (m_pos < 0 && bus.we && ok_addr(int'(bus.wa))) begin
            m_mem[bus.wa]  <= bus.wd;
            m_pend[bus.wa] <= 1'b0;
         end
         if (bus.pend_set && ok_addr(int'(bus.pend_addr)) &&
             !(m_pos >= 0 && m_pos < NR && int'(bus.pend_addr) == m_pos))
            m_pend[bus.pend_addr] <= 1'b1;
         if (m_pos >= 0 && m_pos < NR) begin
            m_mem[m_pos]  <= '0;
            m_pend[m_pos] <= 1'b0;
         end
         if (m_pos < 0)       m_pos <= bus.clr_req ? 0 : -1;
         else if (m_pos < NR) m_pos <= m_pos + 1;
         else                 m_pos <= -1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < RD; i++) begin
            chk($sformatf("m_rd%0d", i), 32'(bus.rd[i]),
                32'(exp_rd(int'(bus.ra[i]))));
            chk($sformatf("m_rdp%0d", i), 32'(bus.rd_pend[i]),
                32'(exp_pend(int'(bus.ra[i]))));
         end
         chk("m_pending", 32'(bus.pending), 32'(m_pend));
         chk("m_busy", 32'(bus.clr_busy), 32'(m_pos >= 0 && m_pos < NR));
         chk("m_done", 32'(bus.clr_done), 32'(m_pos == NR));
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int nb, nd, run1, gap, dn, g;

   initial begin
      rst = 1'b1;
      bus.ra = '0; bus.we = 0; bus.wa = '0; bus.wd = '0;
      bus.ext_val = EXTV; bus.pend_set = 0; bus.pend_addr = '0;
      bus.clr_req = 0;
      bus2.ra = '0; bus2.we = 0; bus2.wa = '0; bus2.wd = '0;
      bus2.ext_val = EXTV; bus2.pend_set = 0; bus2.pend_addr = '0;
      bus2.clr_req = 0;
      tick(2);
      rst = 1'b0;
      chk_en = 1'b1;
      #1;
      chk("rst_busy", 32'(bus.clr_busy), 0);
      chk("rst_done", 32'(bus.clr_done), 0);
      tick();

      // Activity, then reset in the middle of a sweep.
      bus.we = 1; bus.wa = 2; bus.wd = 24'h111111;
      bus.pend_set = 1; bus.pend_addr = 4; bus.ra[0] = 2;
      tick();
      bus.we = 0; bus.pend_set = 0;
      #1;
      chk("pre_r2", 32'(bus.rd[0]), 32'h111111);
      bus.clr_req = 1;
      tick();
      bus.clr_req = 0;
      tick(2);
      rst = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(bus.clr_busy), 0);
      chk("rst_mid_pend", 32'(bus.pending), 0);
      chk("rst_mid_r2", 32'(bus.rd[0]), 0);
      tick();
      rst = 1'b0;
      for (int a = 0; a < NR; a++) begin
         bus.ra[0] = AW'(a); bus.ra[2] = AW'(a);
         #1;
         chk("rst_rd", 32'(bus.rd[2]), (a == EXT) ? 32'(EXTV) : 0);
         tick();
      end

      // Write visibility and ignored write to the ext slot.
      bus.ra[0] = 3; bus.we = 1; bus.wa = 3; bus.wd = 24'h123456;
      #1;
`ifdef RF_BYPASS_EN
      chk("wr3_same", 32'(bus.rd[0]), 32'h123456);
`else
      chk("wr3_same", 32'(bus.rd[0]), 0);
`endif
      tick();
      bus.we = 0;
      #1;
      chk("wr3_next", 32'(bus.rd[0]), 32'h123456);
      bus.we = 1; bus.wa = 11; bus.wd = 24'hFFFFFF; bus.ra[1] = 11;
      tick();
      bus.we = 0;
      #1;
      chk("ext_wr", 32'(bus.rd[1]), 32'(EXTV));

      // Scoreboard set, clear by write, set-wins, independent addrs.
      bus.pend_set = 1; bus.pend_addr = 5; bus.ra[2] = 5;
      tick();
      bus.pend_set = 0;
      #1;
      chk("pend_n1", 32'(bus.pending[5]), 1);
      chk("rdp_n1", 32'(bus.rd_pend[2]), 1);
      tick();
      bus.we = 1; bus.wa = 5; bus.wd = 24'h0A0A05;
      #1;
      chk("pend_n2", 32'(bus.pending[5]), 1);
      tick();
      bus.we = 0;
      #1;
      chk("pend_wr", 32'(bus.pending[5]), 0);
      chk("rd5", 32'(bus.rd[2]), 32'h0A0A05);
      bus.pend_set = 1; bus.pend_addr = 5;
      bus.we = 1; bus.wa = 5; bus.wd = 24'h0B0B05;
      tick();
      bus.pend_set = 0; bus.we = 0;
      #1;
      chk("set_wins", 32'(bus.pending[5]), 1);
      chk("rd5b", 32'(bus.rd[2]), 32'h0B0B05);
      bus.pend_set = 1; bus.pend_addr = 6; bus.ra[0] = 7;
      bus.we = 1; bus.wa = 7; bus.wd = 24'h070707;
      tick();
      bus.pend_set = 0; bus.we = 0;
      #1;
      chk("diff_set", 32'(bus.pending[6]), 1);
      chk("diff_wr", 32'(bus.rd[0]), 32'h070707);

      // Fill, then sweep while trying to write r2.
      for (int i = 0; i < NR; i++) begin
         bus.we = 1; bus.wa = AW'(i); bus.wd = DW'((i + 1) * 24'h010101);
         tick();
      end
      bus.we = 0; bus.ra[1] = 0; bus.ra[0] = 2;
      bus.clr_req = 1;
      tick();
      bus.clr_req = 0;
      bus.we = 1; bus.wa = 2; bus.wd = 24'hABCDEF;
      #1;
      chk("r0_before", 32'(bus.rd[1]), 32'h010101);
      nb = 0; nd = 0;
      for (int k = 0; k < 24; k++) begin
         if (bus.clr_busy) nb++;
         if (bus.clr_done) begin nd++; bus.we = 0; end
         if (k == 1) chk("r0_clr", 32'(bus.rd[1]), 0);
         tick();
         #1;
      end
      bus.we = 0;
      chk("busy_len", 32'(nb), 16);
      chk("done_cnt", 32'(nd), 1);
      chk("sw_pend", 32'(bus.pending), 0);
      for (int a = 0; a < NR; a++) begin
         bus.ra[2] = AW'(a);
         #1;
         chk("sw_rd", 32'(bus.rd[2]), (a == EXT) ? 32'(EXTV) : 0);
         tick();
      end

      // Held request: back-to-back sweeps, then reset on cycle 7.
      bus.clr_req = 1;
      tick();
      #1;
      run1 = 0; gap = 0; dn = 0; g = 0;
      while (bus.clr_busy && g < 40) begin
         run1++; g++; tick(); #1;
      end
      while (!bus.clr_busy && g < 80) begin
         gap++; g++;
         if (bus.clr_done) dn++;
         tick(); #1;
      end
      chk("run1", 32'(run1), 16);
      chk("gap", 32'(gap), 2);
      chk("gap_done", 32'(dn), 1);
      chk("sweep2", 32'(bus.clr_busy), 1);
      bus.pend_set = 1; bus.pend_addr = 0;
      tick();
      bus.pend_set = 0;
      #1;
      chk("clr_wins", 32'(bus.pending[0]), 0);
      tick(2);
      bus.pend_set = 1; bus.pend_addr = 14;
      tick();
      bus.pend_set = 0;
      #1;
      chk("sw_set14", 32'(bus.pending[14]), 1);
      tick(2);
      rst = 1'b1;
      #1;
      chk("rst7_busy", 32'(bus.clr_busy), 0);
      chk("rst7_done", 32'(bus.clr_done), 0);
      chk("rst7_pend", 32'(bus.pending), 0);
      bus.clr_req = 0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst", 32'(bus.clr_busy), 0);

      // Smaller instance: out-of-range, ext slot, identical ports.
      bus2.we = 1; bus2.wa = 5; bus2.wd = 24'h000777;
      bus2.pend_set = 1; bus2.pend_addr = 14;
      tick();
      bus2.we = 0; bus2.pend_set = 0;
      bus2.ra[0] = 5; bus2.ra[1] = 5; bus2.ra[2] = 5;
      #1;
      for (int i = 0; i < RD; i++)
         chk($sformatf("n12_rd5_%0d", i), 32'(bus2.rd[i]), 32'h000777);
      chk("n12_pend", 32'(bus2.pending), 0);
      bus2.ra[0] = 14;
      #1;
      chk("n12_rd14", 32'(bus2.rd[0]), 0);
      chk("n12_rdp14", 32'(bus2.rd_pend[0]), 0);
      bus2.ra[1] = 11;
      #1;
      chk("n12_ext", 32'(bus2.rd[1]), 32'(EXTV));
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
